// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data memory port between the pipeline and a host port with bounded host starvation
module dmem_arbiter #(
  parameter int MAX_STARVE = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             cpu_load,
  input  logic             cpu_store,
  input  logic [1:0]       cpu_size,
  input  logic             cpu_sign_extend,
  input  logic [WIDTH-1:0] cpu_address,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic [WIDTH-1:0] cpu_rdata,
  output logic             cpu_stall,
  input  logic             host_valid,
  input  logic             host_write,
  input  logic [1:0]       host_size,
  input  logic [WIDTH-1:0] host_address,
  input  logic [WIDTH-1:0] host_wdata,
  output logic             host_ready,
  output logic             host_rvalid,
  output logic [WIDTH-1:0] host_rdata,
  output logic             mem_load,
  output logic             mem_store,
  output logic [1:0]       mem_size,
  output logic             mem_sign_extend,
  output logic [WIDTH-1:0] mem_address,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_read_data
);
  logic [3:0] starve_q, starve_d;
  logic cpu_req, grant_host, grant_cpu;
  logic host_rvalid_d;
  logic [WIDTH-1:0] host_rdata_d;
  // grant decision and memory port mux
  always_comb begin
    cpu_req = cpu_load | cpu_store;
    grant_host = host_valid & (!cpu_req | starve_q == 4'(MAX_STARVE));
    grant_cpu = cpu_req & !grant_host;
    host_ready = grant_host;
    cpu_stall = cpu_req & grant_host;
    cpu_rdata = mem_read_data;
    mem_load = grant_host ? !host_write : grant_cpu & cpu_load;
    mem_store = grant_host ? host_write : grant_cpu & cpu_store;
    mem_size = grant_host ? host_size : cpu_size;
    mem_sign_extend = grant_host ? 1'b0 : cpu_sign_extend;
    mem_address = grant_host ? host_address : cpu_address;
    mem_wdata = grant_host ? host_wdata : cpu_wdata;
    starve_d = (grant_host | !host_valid) ? 4'd0 : starve_q + 4'd1;
    host_rvalid_d = grant_host & !host_write;
    host_rdata_d = host_rvalid_d ? mem_read_data : host_rdata;
  end
  // starvation counter and registered host load response
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      starve_q <= 4'd0;
      host_rvalid <= 1'b0;
      host_rdata <= '0;
    end else begin
      starve_q <= starve_d;
      host_rvalid <= host_rvalid_d;
      host_rdata <= host_rdata_d;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of dmem_arbiter against a big-endian byte RAM model
module tb_dmem_arbiter;
  localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2;
  logic clk = 1'b0, nrst = 1'b0;
  logic cpu_load, cpu_store, cpu_sign_extend, cpu_stall;
  logic [1:0] cpu_size;
  logic [31:0] cpu_address, cpu_wdata, cpu_rdata;
  logic host_valid, host_write, host_ready, host_rvalid;
  logic [1:0] host_size;
  logic [31:0] host_address, host_wdata, host_rdata;
  logic mem_load, mem_store, mem_sign_extend;
  logic [1:0] mem_size;
  logic [31:0] mem_address, mem_wdata, mem_read_data;
  logic [7:0] ram [0:255];
  logic [7:0] ra;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  dmem_arbiter #(.MAX_STARVE(4), .WIDTH(32)) dut (
    .clk(clk), .nrst(nrst),
    .cpu_load(cpu_load), .cpu_store(cpu_store), .cpu_size(cpu_size),
    .cpu_sign_extend(cpu_sign_extend), .cpu_address(cpu_address), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .host_valid(host_valid), .host_write(host_write), .host_size(host_size),
    .host_address(host_address), .host_wdata(host_wdata),
    .host_ready(host_ready), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_load(mem_load), .mem_store(mem_store), .mem_size(mem_size),
    .mem_sign_extend(mem_sign_extend), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_read_data(mem_read_data)
  );
  // combinational big-endian read with optional sign extension
  always_comb begin
    ra = mem_address[7:0];
    case (mem_size)
      SZ_B: mem_read_data = {{24{mem_sign_extend & ram[ra][7]}}, ram[ra]};
      SZ_H: mem_read_data = {{16{mem_sign_extend & ram[ra][7]}}, ram[ra], ram[ra+8'd1]};
      default: mem_read_data = {ram[ra], ram[ra+8'd1], ram[ra+8'd2], ram[ra+8'd3]};
    endcase
  end
  // memory write at the clock edge
  always @(posedge clk) begin
    if (mem_store) begin
      case (mem_size)
        SZ_B: ram[ra] <= mem_wdata[7:0];
        SZ_H: begin ram[ra] <= mem_wdata[15:8]; ram[ra+8'd1] <= mem_wdata[7:0]; end
        default: begin
          ram[ra] <= mem_wdata[31:24]; ram[ra+8'd1] <= mem_wdata[23:16];
          ram[ra+8'd2] <= mem_wdata[15:8]; ram[ra+8'd3] <= mem_wdata[7:0];
        end
      endcase
    end
  end
  task automatic next();
    @(posedge clk); #1;
  endtask
  task automatic idle();
    cpu_load = 0; cpu_store = 0; cpu_size = SZ_W; cpu_sign_extend = 0;
    cpu_address = 32'h0; cpu_wdata = 32'h0;
    host_valid = 0; host_write = 0; host_size = SZ_W; host_address = 32'h0; host_wdata = 32'h0;
  endtask
  task automatic test_reset();
    idle();
    cpu_address = 32'h77;
    #2;
    total++; if (host_rvalid !== 1'b0) $display("FAIL reset_rvalid got %0b want 0", host_rvalid); else passed++;
    total++; if (host_rdata !== 32'h0) $display("FAIL reset_rdata got %h want 0", host_rdata); else passed++;
    total++; if ({mem_load, mem_store, host_ready, cpu_stall} !== 4'b0) $display("FAIL reset_idle_ctrl got %b want 0000", {mem_load, mem_store, host_ready, cpu_stall}); else passed++;
    total++; if (mem_address !== 32'h77) $display("FAIL idle_addr_from_cpu got %h want 00000077", mem_address); else passed++;
    next(); next();
    nrst = 1;
  endtask
  task automatic test_cpu_only();
    idle(); cpu_store = 1; cpu_address = 32'h10; cpu_wdata = 32'hDEADBEEF;
    @(negedge clk);
    total++; if ({mem_store, mem_load, cpu_stall} !== 3'b100) $display("FAIL cpu_store_ctrl got %b want 100", {mem_store, mem_load, cpu_stall}); else passed++;
    total++; if (mem_wdata !== 32'hDEADBEEF || mem_address !== 32'h10) $display("FAIL cpu_store_fields got %h@%h want deadbeef@00000010", mem_wdata, mem_address); else passed++;
    next(); cpu_store = 0; cpu_load = 1;
    @(negedge clk);
    total++; if ({mem_store, mem_load, cpu_stall} !== 3'b010) $display("FAIL cpu_load_ctrl got %b want 010", {mem_store, mem_load, cpu_stall}); else passed++;
    total++; if (cpu_rdata !== 32'hDEADBEEF) $display("FAIL cpu_load_data got %h want deadbeef", cpu_rdata); else passed++;
    next(); idle();
  endtask
  task automatic test_host_only();
    idle(); host_valid = 1; host_write = 1; host_size = SZ_B; host_address = 32'h23; host_wdata = 32'hA5;
    @(negedge clk);
    total++; if ({host_ready, mem_store, mem_load} !== 3'b110) $display("FAIL host_store_ctrl got %b want 110", {host_ready, mem_store, mem_load}); else passed++;
    next(); host_write = 0; host_wdata = 32'h0;
    @(negedge clk);
    total++; if ({host_ready, mem_store, mem_load, mem_sign_extend} !== 4'b1010) $display("FAIL host_load_ctrl got %b want 1010", {host_ready, mem_store, mem_load, mem_sign_extend}); else passed++;
    total++; if (host_rvalid !== 1'b0) $display("FAIL host_rvalid_after_store got %0b want 0", host_rvalid); else passed++;
    next(); idle();
    @(negedge clk);
    total++; if (host_rvalid !== 1'b1 || host_rdata !== 32'hA5) $display("FAIL host_load_resp got %0b/%h want 1/000000a5", host_rvalid, host_rdata); else passed++;
    next();
    @(negedge clk);
    total++; if (host_rvalid !== 1'b0 || host_rdata !== 32'hA5) $display("FAIL host_resp_hold got %0b/%h want 0/000000a5", host_rvalid, host_rdata); else passed++;
    host_valid = 1; host_write = 1; host_size = SZ_B; host_address = 32'h50; host_wdata = 32'h55;
    next(); host_valid = 0; cpu_load = 1; cpu_size = SZ_B; cpu_address = 32'h50;
    @(negedge clk);
    total++; if (cpu_rdata !== 32'h55) $display("FAIL host_store_then_cpu_load got %h want 00000055", cpu_rdata); else passed++;
    next(); idle();
  endtask
  task automatic test_starve();
    idle(); cpu_load = 1; cpu_address = 32'h10;
    host_valid = 1; host_size = SZ_B; host_address = 32'h23;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      total++; if (host_ready !== (i % 5 == 4) || cpu_stall !== (i % 5 == 4)) $display("FAIL starve_grant_%0d got %0b%0b want %0b", i, host_ready, cpu_stall, i % 5 == 4); else passed++;
      total++; if (mem_address !== ((i % 5 == 4) ? 32'h23 : 32'h10)) $display("FAIL starve_addr_%0d got %h", i, mem_address); else passed++;
      total++; if (host_rvalid !== (i % 5 == 0 && i > 0)) $display("FAIL starve_rvalid_%0d got %0b want %0b", i, host_rvalid, i % 5 == 0 && i > 0); else passed++;
      next();
    end
    idle(); next();
  endtask
  task automatic test_contest_store();
    idle(); cpu_load = 1; cpu_address = 32'h0;
    host_valid = 1; host_write = 1; host_size = SZ_W; host_address = 32'h40; host_wdata = 32'h11111111;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (mem_store !== 1'b0 || host_ready !== 1'b0) $display("FAIL contest_wait_%0d got %0b%0b want 00", i, mem_store, host_ready); else passed++;
      next();
    end
    cpu_load = 0; cpu_store = 1; cpu_address = 32'h40; cpu_wdata = 32'hCAFEF00D;
    @(negedge clk);
    total++; if ({host_ready, cpu_stall, mem_store} !== 3'b111 || mem_wdata !== 32'h11111111) $display("FAIL contest_host_win got %b/%h want 111/11111111", {host_ready, cpu_stall, mem_store}, mem_wdata); else passed++;
    next(); host_valid = 0;
    @(negedge clk);
    total++; if ({cpu_stall, mem_store} !== 2'b01 || mem_wdata !== 32'hCAFEF00D) $display("FAIL contest_cpu_retry got %b/%h want 01/cafef00d", {cpu_stall, mem_store}, mem_wdata); else passed++;
    next(); cpu_store = 0; cpu_load = 1;
    @(negedge clk);
    total++; if (cpu_rdata !== 32'hCAFEF00D) $display("FAIL contest_final got %h want cafef00d", cpu_rdata); else passed++;
    next(); idle();
  endtask
  task automatic test_reset_mid();
    idle(); host_valid = 1; host_address = 32'h10;
    next(); cpu_load = 1; cpu_address = 32'h0;
    @(negedge clk);
    total++; if (host_rvalid !== 1'b1 || host_rdata !== 32'hDEADBEEF) $display("FAIL pre_reset_resp got %0b/%h want 1/deadbeef", host_rvalid, host_rdata); else passed++;
    nrst = 0; #1;
    total++; if (host_rvalid !== 1'b0 || host_rdata !== 32'h0) $display("FAIL async_reset_resp got %0b/%h want 0/0", host_rvalid, host_rdata); else passed++;
    next(); nrst = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (host_ready !== (i == 4)) $display("FAIL post_reset_starve_%0d got %0b want %0b", i, host_ready, i == 4); else passed++;
      next();
    end
    idle(); next();
  endtask
  task automatic test_sign();
    idle(); host_valid = 1; host_write = 1; host_size = SZ_H; host_address = 32'h30; host_wdata = 32'h8001;
    next(); host_write = 0; host_wdata = 32'h0;
    @(negedge clk);
    total++; if (mem_sign_extend !== 1'b0 || host_ready !== 1'b1) $display("FAIL host_half_ctrl got %0b%0b want 01", mem_sign_extend, host_ready); else passed++;
    next(); idle(); cpu_load = 1; cpu_size = SZ_H; cpu_sign_extend = 1; cpu_address = 32'h30;
    @(negedge clk);
    total++; if (host_rvalid !== 1'b1 || host_rdata !== 32'h00008001) $display("FAIL host_half_data got %0b/%h want 1/00008001", host_rvalid, host_rdata); else passed++;
    total++; if (cpu_rdata !== 32'hFFFF8001 || mem_sign_extend !== 1'b1) $display("FAIL cpu_half_sext got %h/%0b want ffff8001/1", cpu_rdata, mem_sign_extend); else passed++;
    next(); idle();
  endtask
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'h0;
    test_reset();
    test_cpu_only();
    test_host_only();
    test_starve();
    test_contest_store();
    test_reset_mid();
    test_sign();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory (byte-addressed RAM, big-endian, combinational read, write at clock edge) between the pipeline memory stage and a host/debug access port. Sits between the execute-stage memory controls and the data memory. The pipeline normally has priority. A bounded-starvation counter guarantees the host a slot. When the host wins a contested cycle, the block stalls the pipeline.

## Interface
Parameters:
- MAX_STARVE, 4: number of consecutive contested cycles the host may lose before it is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- cpu_load, cpu_store  in  1 each  pipeline access request; never both high.
- cpu_size  in  2  Decode::LoadStoreDataSizeMode_* code.
- cpu_sign_extend  in  1  sign-extend for loads.
- cpu_address, cpu_wdata  in  Constants::WIDTH each.
- cpu_rdata  out  Constants::WIDTH  load data; combinational passthrough of mem_read_data.
- cpu_stall  out  1  pipeline must hold its request this cycle.
- host_valid  in  1  host request pending.
- host_write  in  1  1 = store, 0 = load.
- host_size  in  2, host_address  in  WIDTH, host_wdata  in  WIDTH  host request fields; sign extension is always 0.
- host_ready  out  1  host request accepted this cycle.
- host_rvalid  out  1  registered host load data valid.
- host_rdata  out  WIDTH  registered host load data.
- mem_load, mem_store  out  1 each  to data memory.
- mem_size  out  2, mem_sign_extend  out  1, mem_address  out  WIDTH, mem_wdata  out  WIDTH  to data memory.
- mem_read_data  in  WIDTH  from data memory.

## Operation
- cpu_req = cpu_load | cpu_store.
- Contested cycle: cpu_req & host_valid.
- grant_host = host_valid & (!cpu_req | starve_cnt == MAX_STARVE).
- grant_cpu = cpu_req & !grant_host.
- host_ready = grant_host. cpu_stall = cpu_req & grant_host.
- Memory mux, selected by grant:
  - grant_cpu: cpu fields drive mem_*.
  - grant_host: mem_load = !host_write, mem_store = host_write, host fields drive the rest, mem_sign_extend = 0.
  - Neither granted: mem_load = mem_store = 0; address, data and size outputs are don't-care but must be driven from the cpu fields.
- A stalled cpu store must never reach mem_store.
- starve_cnt, 4 bits, registered, reset 0:
  - contested & grant_cpu: increment, saturating at MAX_STARVE.
  - grant_host or !host_valid: reset to 0.
  - Otherwise: hold.
- Host response register:
  - On grant_host & !host_write: capture mem_read_data into host_rdata and set host_rvalid = 1 for the next cycle.
  - Otherwise host_rvalid = 0.
  - host_rdata holds its last value when host_rvalid is 0.
- Host handshake: the host holds all request fields stable while host_valid & !host_ready. The host may issue a back-to-back request in the cycle host_rvalid is high.
- cpu_rdata always equals mem_read_data. The pipeline samples it only when !cpu_stall.

## Timing
- Reset values: starve_cnt 0, host_rvalid 0, host_rdata 0. All other outputs are combinational from inputs and state.
- Grant decision, host_ready, cpu_stall and mem_* are combinational in the same cycle as the request. Stores commit at the rising edge that ends the grant cycle.
- Host load latency is 1 cycle: grant at cycle N, host_rvalid/host_rdata valid in cycle N+1 only.
- Host throughput is one access per cycle when the pipeline is idle. Under continuous cpu_req, the host gets exactly one grant every MAX_STARVE+1 cycles.
- A host store and a cpu load to the same address in adjacent cycles behave as sequential: the cpu load after the host grant sees the new data.
- Asserting nrst mid-access clears host_rvalid and starve_cnt immediately. A store in flight at the reset edge is not guaranteed.
- host_valid dropping before ready is a protocol violation; starve_cnt resets to 0 and no access occurs.

## Test plan
- Host idle; cpu word store 0xDEADBEEF to 0x10, then cpu word load from 0x10 -> mem_store high for one cycle, cpu_rdata = 0xDEADBEEF, cpu_stall stays 0.
- Cpu idle; host byte store 0xA5 to 0x23, then host byte load from 0x23 -> host_ready high on both requests, host_rvalid one cycle after the load, host_rdata = 0x000000A5.
- cpu_load held high continuously, host_valid high with MAX_STARVE = 4 -> host_ready and cpu_stall high together on exactly the 5th cycle, then every 5th cycle; starve_cnt sequence 0,1,2,3,4,0.
- Contested cycle with a cpu store to 0x40 while the host is granted a store of 0x11111111 to 0x40 -> mem_store carries host data only; the cpu store commits the next cycle (0x40 ends with the cpu value); no double write.
- Host load granted, nrst pulsed low in the following cycle -> host_rvalid = 0 and host_rdata = 0 immediately; starve_cnt = 0 after release.
- Host halfword load, sign-extend check: RAM 0x30..0x31 = 0x80,0x01 -> host_rdata = 0x00008001 (no sign extension); the same access from cpu with cpu_sign_extend = 1 -> cpu_rdata = 0xFFFF8001.
